keycode_tx: RTL
===============

Name: keycode_tx

Overview:
- Transmit side of the keypad-lock interface: sends a stored DIGITS-digit code to a keylock, one 4-bit digit per cycle, then watches the lock's locked output to report unlock success or failure.
- Used as the bench/system-side driver for the keylock FSM.
- The keylock samples its key input every clock, so non-digit cycles drive an idle code (4'hF) that never matches a digit.

Parameters:
- DIGITS, 6, number of digits per code (1..15).
- GAP, 0, idle cycles inserted between consecutive digits (0..15).
- TIMEOUT, 8, number of WAIT-state cycles in which locked_in is sampled before declaring failure (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a transmission; sampled only in IDLE.
- code_in  input  4*DIGITS  code to send; digit 0 in bits [3:0] is sent first; latched on accepted start.
- locked_in  input  1  locked output of the keylock (1 = locked).
- key_out  output  4  registered key digit to the lock; 4'hF when not sending a digit.
- key_valid  output  1  registered; high exactly in cycles where key_out carries a code digit.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle completion pulse.
- success  output  1  result of the last transmission; valid with done and held until the next accepted start or reset.
- bad_code  output  1  high with done when the latched code contained a digit > 9; held like success.

Behaviour:
- Clock and reset: clk, rising edge; reset is asynchronous, active-high.
- Reset values: key_out=4'hF, key_valid=0, busy=0, done=0, success=0, bad_code=0, state=IDLE, counters=0.
- Reset mid-operation aborts immediately to the reset values. No done pulse is produced.
- States:
  - IDLE: outputs idle. start=1 at edge E latches code_in and clears success/bad_code. Next state is CHECK-then-SEND, evaluated in the same edge.
  - Code check is combinational on code_in at edge E. If any digit > 9, go to DONE: cycle E+1 has done=1, success=0, bad_code=1, busy=0, and no digit is sent.
  - SEND: digit i is presented for exactly one cycle (key_out=digit i, key_valid=1). With GAP=0, digits occupy cycles E+1..E+DIGITS. After the last digit, go to WAIT.
  - GAP: after each non-final digit, GAP cycles with key_out=4'hF, key_valid=0. No gap follows the last digit.
  - WAIT: key_out=4'hF, key_valid=0. locked_in is sampled each cycle for up to TIMEOUT cycles.
    - First sample with locked_in=0: go to DONE with success=1.
    - TIMEOUT samples all 1: go to DONE with success=0.
  - DONE: one cycle with done=1 and busy=0, then IDLE. A start in the DONE cycle is ignored.
- Latency, GAP=0, correct code, lock unlocks combinationally after its registered state update:
  - Last digit is in cycle E+DIGITS.
  - locked_in=0 in cycle E+DIGITS+1 and is sampled at the end of that cycle.
  - done=1 in cycle E+DIGITS+2.
- Latency, failure: done=1 in cycle E+DIGITS+(DIGITS-1)*GAP+TIMEOUT+1.
- busy=1 during SEND, GAP and WAIT. start while busy is ignored, and code_in changes while busy have no effect.
- Counters:
  - Digit index: width ceil(log2(DIGITS+1)).
  - Gap counter: 4 bits.
  - Timeout counter: width ceil(log2(TIMEOUT+1)). Counters do not wrap; each is cleared on entering its state.
- locked_in is ignored outside WAIT. A lock that is already open before start still requires a WAIT-state sample.

Test Plan:
- DIGITS=6, GAP=0, code 3,3,5,2,5,6, keylock model attached, start at edge E:
  - key_out = 3,3,5,2,5,6 in cycles E+1..E+6 with key_valid=1.
  - Cycle E+7: key_out=F.
  - Cycle E+8: done=1, success=1, bad_code=0. success stays 1 afterwards.
- Code 3,3,5,2,5,7 with keylock model: lock stays locked. done in cycle E+7+8=E+15 with success=0; busy=1 in cycles E+1..E+14.
- Code with digit 2 = 4'hA: cycle E+1 has done=1, bad_code=1, success=0; key_valid never asserts.
- GAP=2, code 3,3,5,2,5,6, lock model that ignores key_valid=0 cycles:
  - Each digit is followed by 2 cycles of key_out=F, key_valid=0 (none after digit 6).
  - Last digit in cycle E+16; done=1 in cycle E+18 with success=1.
- start re-pulsed in cycles E+2 and E+DIGITS+2 (the DONE cycle) with a different code_in: no effect on the sent digits or the result. The next start in IDLE is accepted normally.
- reset asserted asynchronously mid-SEND (cycle E+3):
  - Outputs take reset values immediately and done never pulses.
  - After release, a new start sends the full sequence from digit 0.

Source files
------------

// File: rtl/keycode_tx.sv
// keycode_tx -- transmit side of the keypad-lock interface.
// Sends a latched DIGITS-digit code to a keylock, one 4-bit digit per
// cycle (optionally separated by GAP idle cycles), then samples the lock's
// locked output for up to TIMEOUT cycles to decide success or failure.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      begin a transmission (only honoured in IDLE)
//   code_in    code to send, digit 0 in [3:0] goes first
//   locked_in  keylock locked output (1 = locked), looked at only in WAIT
//   key_out    registered digit to the lock, 4'hF when no digit is sent
//   key_valid  registered, high exactly when key_out carries a digit
//   busy       high during SEND / GAP / WAIT
//   done       one-cycle completion pulse
//   success    result of last transmission, held until next start
//   bad_code   latched code held a digit > 9, held like success
module keycode_tx #(
    parameter int DIGITS  = 6,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   code_in,
    input  logic                  locked_in,
    output logic [3:0]            key_out,
    output logic                  key_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic                  bad_code
);

    localparam int IW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, GAPS, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [3:0]          gap_cnt, gap_nxt;
    logic [TW-1:0]       to_cnt, to_nxt;
    logic [4*DIGITS-1:0] code_r;
    logic                latch;
    logic                succ_nxt, bad_nxt;
    logic                code_bad;
    logic [4*DIGITS-1:0] src;
    logic [3:0]          key_nxt;
    logic                valid_nxt, busy_nxt, done_nxt;

    // Validity check looks at code_in directly so a bad code is caught on
    // the accepting edge itself.
    always_comb begin
        code_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (code_in[4*i +: 4] > 4'd9) code_bad = 1'b1;
    end

    // State / counter register, plus the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            code_r    <= '0;
            key_out   <= 4'hF;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            success   <= 1'b0;
            bad_code  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_nxt;
            to_cnt    <= to_nxt;
            if (latch) code_r <= code_in;
            key_out   <= key_nxt;
            key_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            success   <= succ_nxt;
            bad_code  <= bad_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        to_nxt    = to_cnt;
        latch     = 1'b0;
        succ_nxt  = success;
        bad_nxt   = bad_code;
        case (state)
            IDLE: begin
                if (start) begin
                    latch    = 1'b1;
                    succ_nxt = 1'b0;
                    bad_nxt  = 1'b0;
                    idx_nxt  = '0;
                    if (code_bad) begin
                        state_nxt = DONE;
                        bad_nxt   = 1'b1;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                if (idx == IW'(DIGITS - 1)) begin
                    state_nxt = WAIT;
                    to_nxt    = '0;
                end else if (GAP == 0) begin
                    idx_nxt = idx + 1'b1;
                end else begin
                    state_nxt = GAPS;
                    gap_nxt   = '0;
                end
            end
            GAPS: begin
                if (gap_cnt == 4'(GAP - 1)) begin
                    state_nxt = SEND;
                    idx_nxt   = idx + 1'b1;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!locked_in) begin
                    state_nxt = DONE;
                    succ_nxt  = 1'b1;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state_nxt = DONE;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // outputs come straight from flops. On the accepting edge the latched
    // copy is not yet loaded, so digit 0 is taken from code_in.
    always_comb begin
        src       = (state == IDLE) ? code_in : code_r;
        key_nxt   = 4'hF;
        valid_nxt = 1'b0;
        if (state_nxt == SEND) begin
            valid_nxt = 1'b1;
            for (int i = 0; i < DIGITS; i++)
                if (idx_nxt == IW'(i)) key_nxt = src[4*i +: 4];
        end
        busy_nxt = (state_nxt == SEND) || (state_nxt == GAPS) || (state_nxt == WAIT);
        done_nxt = (state_nxt == DONE);
    end

endmodule
